// File: rtl/riscv_defs_pkg.sv
// Shared definitions for the RISC-V core front end.
//
// Contents:
//   DEFAULT_RESET_PC  PC loaded into the fetch unit on reset.
//   DEFAULT_NOP_INS   addi x0,x0,0. It is presented to IF/ID whenever no real
//                     instruction is buffered.
//   fetch_state_e     Fetch FSM encodings. These are fixed so that a checker
//                     bound to the debug state output can decode them.
package riscv_defs;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INS  = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_out_buffer.sv
// fetch_out_buffer: the output buffer that feeds IF/ID, plus a one-entry hold
// register. The hold register catches a returning fetch while the buffer is
// stalled.
//
// Ports:
//   clk, reset         clock; asynchronous active-low reset
//   push               a fetched word (push_pc/push_ins) arrives this edge
//   consume            IF/ID takes the buffered word this edge (not stalled)
//   flush              redirect: drop buffer and hold contents
//   push_pc, push_ins  PC and instruction of the arriving word
//   full               the buffer holds a real instruction
//   hold_full          the hold register holds a word waiting for the buffer
//   buf_pc, buf_ins    buffered PC / instruction
module fetch_out_buffer
    import riscv_defs::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        consume,
    input  logic        flush,
    input  logic [31:0] push_pc,
    input  logic [31:0] push_ins,
    output logic        full,
    output logic        hold_full,
    output logic [31:0] buf_pc,
    output logic [31:0] buf_ins
);

    logic        buf_valid;
    logic [31:0] hold_pc;
    logic [31:0] hold_ins;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_valid <= 1'b0;
            buf_pc    <= 32'd0;
            buf_ins   <= 32'd0;
            hold_full <= 1'b0;
            hold_pc   <= 32'd0;
            hold_ins  <= 32'd0;
        end else if (flush) begin
            // Addresses are kept. Only the valid flags matter after a flush.
            buf_valid <= 1'b0;
            hold_full <= 1'b0;
        end else if (push) begin
            if (!buf_valid || consume) begin
                buf_valid <= 1'b1;
                buf_pc    <= push_pc;
                buf_ins   <= push_ins;
            end else begin
                hold_full <= 1'b1;
                hold_pc   <= push_pc;
                hold_ins  <= push_ins;
            end
        end else if (consume) begin
            // A push never coincides with a full hold register, because the
            // FSM does not fetch while in HOLD.
            if (hold_full) begin
                buf_valid <= 1'b1;
                buf_pc    <= hold_pc;
                buf_ins   <= hold_ins;
                hold_full <= 1'b0;
            end else begin
                buf_valid <= 1'b0;
            end
        end
    end

    assign full = buf_valid;

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: the IF stage of the 5-stage RISC-V core.
// It owns the PC, keeps one instruction-memory request outstanding at a time,
// and feeds the IF/ID register through fetch_out_buffer.
//
// Handshakes:
//   An address beat is transferred on a rising edge where imem_req=1 and
//   imem_ready=1. imem_req depends only on the FSM state and reset, never on
//   imem_ready.
//   A read-data beat is transferred on any rising edge where imem_rvalid=1.
//   There is no backpressure. Data outside the WAIT state is ignored.
//   IF/ID consumes the buffered word on every rising edge where stall_i=0.
//
// Ports:
//   clk, reset                 clock; asynchronous active-low reset
//   stall_i                    hazard stall; 1 = IF/ID holds this cycle
//   redirect_valid/redirect_pc taken branch/jump from EX (pc bits [1:0] ignored)
//   imem_req/imem_addr/imem_ready      address channel
//   imem_rvalid/imem_rdata             read-data channel
//   PC_out/ins_out/valid_out   to the IF/ID register
//   fsm_state                  debug view of the fetch FSM
module instruction_fetch_unit
    import riscv_defs::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INS  = DEFAULT_NOP_INS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall_i,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_ready,
    input  logic         imem_rvalid,
    input  logic [31:0]  imem_rdata,
    output logic [31:0]  PC_out,
    output logic [31:0]  ins_out,
    output logic         valid_out,
    output fetch_state_e fsm_state
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic         kill_q, kill_d;

    logic         push;
    logic         buf_full;
    logic         hold_full;
    logic [31:0]  buf_pc;
    logic [31:0]  buf_ins;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= FETCH_REQ;
            pc_q     <= RESET_PC_ALIGNED;
            req_pc_q <= 32'd0;
            kill_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            kill_q   <= kill_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        kill_d   = kill_q;
        push     = 1'b0;

        case (state_q)
            FETCH_REQ: begin
                if (imem_ready) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                    state_d  = FETCH_WAIT;
                    // A redirect on the accept edge kills the request just issued.
                    kill_d   = redirect_valid;
                end
            end
            FETCH_WAIT: begin
                if (imem_rvalid) begin
                    state_d = FETCH_REQ;
                    kill_d  = 1'b0;
                    if (!kill_q && !redirect_valid) begin
                        push = 1'b1;
                        if (buf_full && stall_i) begin
                            state_d = FETCH_HOLD;
                        end
                    end
                end else if (redirect_valid) begin
                    kill_d = 1'b1;
                end
            end
            FETCH_HOLD: begin
                // The held word moves into the buffer on the first unstalled edge.
                if (redirect_valid || !stall_i || !hold_full) begin
                    state_d = FETCH_REQ;
                end
            end
            default: begin
                state_d = FETCH_REQ;
            end
        endcase

        // A redirect overrides the +4 increment, including on an accept edge.
        if (redirect_valid) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end
    end

    // The state register already sits in REQ during reset. Gating with reset
    // keeps the request low until reset is released.
    assign imem_req  = reset && (state_q == FETCH_REQ);
    assign imem_addr = pc_q;
    assign fsm_state = state_q;

    fetch_out_buffer u_out_buffer (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .consume   (!stall_i),
        .flush     (redirect_valid),
        .push_pc   (req_pc_q),
        .push_ins  (imem_rdata),
        .full      (buf_full),
        .hold_full (hold_full),
        .buf_pc    (buf_pc),
        .buf_ins   (buf_ins)
    );

    assign PC_out    = buf_pc;
    assign ins_out   = buf_full ? buf_ins : NOP_INS;
    assign valid_out = buf_full;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // main instance signals
  logic        reset = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] PC_out;
  logic [31:0] ins_out;
  logic        valid_out;
  logic [1:0]  fsm_state;

  // wrap-around instance signals
  logic        reset2 = 1'b0;
  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic [31:0] PC_out2;
  logic [31:0] ins_out2;
  logic        valid_out2;
  logic [1:0]  fsm_state2;

  instruction_fetch_unit u_dut (
    .clk(clk), .reset(reset), .stall_i(stall_i),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .PC_out(PC_out), .ins_out(ins_out), .valid_out(valid_out),
    .fsm_state(fsm_state)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(reset2), .stall_i(1'b0),
    .redirect_valid(1'b0), .redirect_pc(32'd0),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ready(1'b1),
    .imem_rvalid(1'b1), .imem_rdata(32'hCAFE_0001),
    .PC_out(PC_out2), .ins_out(ins_out2), .valid_out(valid_out2),
    .fsm_state(fsm_state2)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];        // {pc, ins} in expected delivery order
  logic [31:0] exp_addr_q[$];   // expected accepted fetch addresses
  int          pop_cyc_q[$];
  int          mem_lat = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_fetch(input logic [31:0] a, input bit delivered);
    exp_addr_q.push_back(a);
    if (delivered) exp_q.push_back({a, mem_word(a)});
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || exp_addr_q.size() != 0) && n < limit) begin
      wait_edges(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || exp_addr_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d words and %0d addresses still pending after %0d cycles",
               name, exp_q.size(), exp_addr_q.size(), limit);
      exp_q.delete();
      exp_addr_q.delete();
    end
  endtask

  // ---------------- memory model (checks accepted addresses) ----------------
  initial begin
    logic [31:0] a;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    forever begin
      @(negedge clk);
      if (reset && imem_req && imem_ready) begin
        a = imem_addr;
        if (exp_addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fetch_addr: got unexpected request %h expected none", a);
        end else begin
          check("fetch_addr", a, exp_addr_q.pop_front());
        end
        @(posedge clk);
        #1;
        repeat (mem_lat - 1) begin
          @(posedge clk);
          #1;
        end
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(a);
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
      end
    end
  end

  // ---------------- monitor: compares each consumed instruction ----------------
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (reset && valid_out && !stall_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ins_out: got unexpected pc %h ins %h expected none", PC_out, ins_out);
        end else begin
          e = exp_q.pop_front();
          check("out_pc", PC_out, e[63:32]);
          check("out_ins", ins_out, e[31:0]);
          pop_cyc_q.push_back(cyc);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- directed stimulus ----------------
  initial begin
    // Reset state.
    wait_edges(3);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_ins", ins_out, NOP);
    check("rst_pc", PC_out, 32'd0);

    // Streaming fetch: addresses 0, 4, 8, one word every 2 cycles.
    expect_fetch(32'h0, 1);
    expect_fetch(32'h4, 1);
    expect_fetch(32'h8, 1);
    pop_cyc_q.delete();
    imem_ready = 1'b1;
    reset = 1'b1;
    wait_edges(5);
    imem_ready = 1'b0;
    wait_drain("stream", 20);
    if (pop_cyc_q.size() >= 3) begin
      check("stream_gap1", pop_cyc_q[1] - pop_cyc_q[0], 32'd2);
      check("stream_gap2", pop_cyc_q[2] - pop_cyc_q[1], 32'd2);
    end else begin
      checks++;
      errors++;
      $display("FAIL stream_count: got %0d deliveries expected 3", pop_cyc_q.size());
    end
    wait_edges(1);

    // Stall with a full buffer: the word at 16 waits in HOLD.
    expect_fetch(32'hC, 1);
    expect_fetch(32'h10, 1);
    stall_i = 1'b1;
    imem_ready = 1'b1;
    wait_edges(3);
    imem_ready = 1'b0;
    wait_edges(1);
    check("hold_state", {30'd0, fsm_state}, 32'd2);
    check("hold_req", {31'd0, imem_req}, 32'd0);
    check("hold_pc", PC_out, 32'hC);
    check("hold_ins", ins_out, mem_word(32'hC));
    wait_edges(2);
    check("hold_pc_frozen", PC_out, 32'hC);
    check("hold_valid", {31'd0, valid_out}, 32'd1);
    stall_i = 1'b0;
    wait_edges(1);
    check("unhold_pc", PC_out, 32'h10);
    wait_drain("stall", 20);
    wait_edges(1);

    // Redirect during WAIT: the word at 20 is killed and the fetch restarts at 0x100.
    mem_lat = 3;
    expect_fetch(32'h14, 0);
    expect_fetch(32'h100, 1);
    imem_ready = 1'b1;
    wait_edges(1);
    imem_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    wait_edges(1);
    redirect_valid = 1'b0;
    imem_ready = 1'b1;
    check("redir_wait_valid", {31'd0, valid_out}, 32'd0);
    wait_edges(2);
    check("redir_wait_addr", imem_addr, 32'h100);
    check("redir_wait_req", {31'd0, imem_req}, 32'd1);
    wait_edges(1);
    imem_ready = 1'b0;
    check("redir_wait_bubble", {31'd0, valid_out}, 32'd0);
    wait_drain("redir_wait", 20);
    wait_edges(1);

    // Redirect on the accept edge: the request at 0x104 is dropped.
    mem_lat = 1;
    expect_fetch(32'h104, 0);
    expect_fetch(32'h200, 1);
    imem_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    wait_edges(1);
    redirect_valid = 1'b0;
    wait_edges(1);
    check("redir_acc_addr", imem_addr, 32'h200);
    check("redir_acc_valid", {31'd0, valid_out}, 32'd0);
    wait_edges(1);
    imem_ready = 1'b0;
    wait_drain("redir_acc", 20);
    wait_edges(1);

    // Redirect under stall flushes the buffer.
    expect_fetch(32'h204, 0);
    stall_i = 1'b1;
    imem_ready = 1'b1;
    wait_edges(1);
    imem_ready = 1'b0;
    wait_edges(1);
    check("flush_pre_valid", {31'd0, valid_out}, 32'd1);
    check("flush_pre_pc", PC_out, 32'h204);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0300;
    wait_edges(1);
    redirect_valid = 1'b0;
    check("flush_valid", {31'd0, valid_out}, 32'd0);
    check("flush_ins", ins_out, NOP);
    check("flush_addr", imem_addr, 32'h300);
    stall_i = 1'b0;
    wait_drain("flush", 10);

    // Reset asserted mid-WAIT.
    mem_lat = 3;
    expect_fetch(32'h300, 0);
    imem_ready = 1'b1;
    wait_edges(1);
    imem_ready = 1'b0;
    check("midwait_state", {30'd0, fsm_state}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_req", {31'd0, imem_req}, 32'd0);
    check("midrst_valid", {31'd0, valid_out}, 32'd0);
    check("midrst_ins", ins_out, NOP);
    check("midrst_pc", PC_out, 32'd0);
    check("midrst_state", {30'd0, fsm_state}, 32'd0);
    wait_edges(5);
    mem_lat = 1;
    expect_fetch(32'h0, 1);
    imem_ready = 1'b1;
    reset = 1'b1;
    wait_edges(1);
    imem_ready = 1'b0;
    wait_drain("post_reset", 20);

    // RESET_PC = FFFF_FFFC wraps to 0 on the second fetch.
    check("wrap_rst_req", {31'd0, imem_req2}, 32'd0);
    reset2 = 1'b1;
    #1;
    check("wrap_addr0", imem_addr2, 32'hFFFF_FFFC);
    check("wrap_req0", {31'd0, imem_req2}, 32'd1);
    wait_edges(1);
    check("wrap_wait_req", {31'd0, imem_req2}, 32'd0);
    wait_edges(1);
    check("wrap_addr1", imem_addr2, 32'h0000_0000);
    check("wrap_valid", {31'd0, valid_out2}, 32'd1);
    check("wrap_pc", PC_out2, 32'hFFFF_FFFC);
    check("wrap_ins", ins_out2, 32'hCAFE_0001);

    wait_edges(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Pipeline stage 1 (IF) of the 5-stage RISC-V core; drives the IF/ID pipeline register directly.
- Owns the program counter and issues one instruction-memory request at a time over a req/ready address channel and an rvalid data channel.
- Buffers the fetched word plus its PC for the IF/ID register, holds it while the hazard unit stalls, and flushes on branch/jump redirects from EX.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INS, 32'h0000_0013 (addi x0,x0,0), instruction presented when no valid fetch is buffered.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low (asserted at 0); all state clears immediately on assertion.
- stall_i  in  1  hazard-unit stall; 1 = IF/ID does not consume this cycle.
- redirect_valid  in  1  one-cycle pulse from EX: taken branch or jump.
- redirect_pc  in  32  redirect target; bits [1:0] ignored and treated as 0.
- imem_req  out  1  address-channel request.
- imem_addr  out  32  fetch address; bits [1:0] always 0.
- imem_ready  in  1  memory accepts the request on this edge when imem_req=1.
- imem_rvalid  in  1  read data valid; always accepted, no backpressure.
- imem_rdata  in  32  instruction word.
- PC_out  out  32  PC of the buffered instruction, to IF/ID PC_in.
- ins_out  out  32  buffered instruction, to IF/ID ins_in.
- valid_out  out  1  buffered instruction is real; 0 = bubble.

Behaviour:
- State: pc_q, req_pc, kill, FSM {REQ, WAIT, HOLD}, output buffer (buf_valid, buf_pc, buf_ins), hold register (hold_pc, hold_ins).
- Reset values:
  - pc_q=RESET_PC, FSM=REQ, kill=0, buf_valid=0.
  - PC_out=0, ins_out=NOP_INS, valid_out=0.
  - imem_req=0 while reset is asserted.
- Output mapping: PC_out=buf_pc, ins_out=buf_valid ? buf_ins : NOP_INS, valid_out=buf_valid.
- Consumption: the buffer is consumed at every rising edge with stall_i=0.
- REQ state:
  - imem_req=1, imem_addr=pc_q.
  - On imem_ready: req_pc<=pc_q, pc_q<=pc_q+4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0), go WAIT.
- WAIT state:
  - imem_req=0; wait for imem_rvalid.
  - If kill=1: discard the data, clear kill, go REQ.
  - Else if the buffer is empty or consumed this edge: buffer <= {req_pc, rdata}, valid=1, go REQ.
  - Else: hold <= {req_pc, rdata}, go HOLD.
- HOLD state:
  - imem_req=0.
  - On the first edge with stall_i=0: buffer <= hold, go REQ.
- Buffer drain: when consumed with no new data arriving, buf_valid<=0.
- Latency:
  - Request accepted at edge N, rvalid sampled at edge M>N, valid_out=1 after edge M.
  - Best case is one instruction per 2 cycles (single outstanding request).
- Redirect (priority over everything except reset; wins over a simultaneous stall_i):
  - pc_q<=redirect_pc & ~3.
  - buf_valid<=0; hold discarded.
  - HOLD goes to REQ. WAIT without rvalid this edge: kill<=1, stay WAIT. WAIT with rvalid this edge: data dropped, go REQ.
  - REQ with imem_ready this edge: the accepted request is killed (kill<=1, go WAIT) and pc_q takes the redirect target, not +4. REQ without imem_ready: stay REQ.
- Reset asserted mid-WAIT: state clears. The memory-side response to the abandoned request is the memory's responsibility; the core resets both together.
- imem_rvalid outside WAIT is ignored.

Decomposition:
- Shared header/package riscv_defs: NOP_INS value, RESET_PC default, fetch FSM state encodings (REQ=2'd0, WAIT=2'd1, HOLD=2'd2).
- One sub-module: fetch_out_buffer, containing the output buffer plus hold register. Inputs: push, consume, flush. Outputs: full, hold_full.
- PC and FSM logic stay in the top module.

Test Plan:
- Reset release, imem_ready=1, rvalid one cycle after each accept, stall_i=0 -> imem_addr 0,4,8; valid_out pulses with PC_out 0,4,8 and matching ins_out, every 2 cycles.
- Reset held low -> imem_req=0, valid_out=0, ins_out=32'h00000013, PC_out=0; asserting reset mid-WAIT returns all outputs to these values immediately.
- stall_i=1 for 5 cycles with the buffer full and one fetch returning -> PC_out/ins_out frozen; no imem_req in HOLD; after stall drops, the held word (PC+4) appears on the next edge.
- redirect_valid with redirect_pc=32'h0000_0103 while in WAIT -> the next rvalid data is discarded, the next imem_addr is 32'h0000_0100, and valid_out=0 until that word returns.
- redirect_valid on the same edge as imem_ready -> that request's data is dropped and the next request goes to the redirect target; redirect with stall_i=1 -> buffer flushed (valid_out=0).
- RESET_PC=32'hFFFF_FFFC -> first fetch at FFFF_FFFC, second fetch at 0000_0000 (wrap-around).
